keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
- Front-end that drives the combination lock's input side (x, enter, lock) from a physical 4x4 matrix keypad.
- Scans keypad columns, synchronizes and debounces the row returns, and decodes the pressed key.
- Emits exactly one single-cycle strobe per debounced press, in the x/enter/lock format the lock consumes.
- Sits between the board keypad pins and combination_lock in the top level.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven (dwell); minimum 4.
- DEBOUNCE_CNT, 4: consecutive matching scan ticks required to accept a press or a release; minimum 1.
- REPEAT_TICKS, 64: ticks between auto-repeat strobes; used only with KEYPAD_REPEAT_EN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- row_n  input  4  keypad rows, active-low (external pull-ups); asynchronous.
- col_n  output  4  keypad column drive, active-low, one-hot-low.
- x  output  4  last accepted digit, 0-9.
- enter  output  1  one-cycle strobe: digit accepted, x valid this cycle.
- lock  output  1  one-cycle strobe: lock key accepted.
- key_held  output  1  high while a debounced key is held (EMIT/RELEASE states).

Behaviour:
- Reset (asynchronous, rst_n low): col_n=4'b1110, x=0, enter=0, lock=0, key_held=0, state=SCAN, all counters 0, synchronizer flops=4'b1111. Reset mid-debounce or mid-hold discards the key with no strobe.
- row_n passes through a 2-flop synchronizer; all decisions use the synchronized value rs.
- Dwell counter runs 0..SCAN_DIV-1. A "tick" is the cycle the count equals SCAN_DIV-1; rows are sampled only on ticks. Column index c advances (0→1→2→3→0) after a tick only in SCAN.
- Single-row rule: a press is valid only if exactly one bit of rs is 0. Multiple low rows are treated as no key.
- Keymap (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- FSM:
  - SCAN: on a tick with a valid single row r, latch key=(r,c), clear stable counter, go to DEBOUNCE with the column held. Otherwise advance the column.
  - DEBOUNCE: on each tick, if the same single row is low, increment the stable counter; at DEBOUNCE_CNT go to EMIT. Any mismatch or release returns to SCAN and advances the column.
  - EMIT (1 cycle):
    - Digit: x<=value and enter=1 in the same cycle.
    - '*': lock=1, x unchanged.
    - '#' and A-D: no strobe.
    - Then go to RELEASE.
  - RELEASE: column held. On each tick, rs==4'b1111 increments the release counter and any low row clears it. At DEBOUNCE_CNT, return to SCAN and advance the column.
- Latency: first detecting tick T → strobe in the cycle after tick T+DEBOUNCE_CNT ticks.
- enter and lock are never both high. At most one strobe per press. No strobe is ever generated in SCAN or DEBOUNCE.
- A second key pressed while one is held is ignored until full release.
- All counters saturate or wrap only within their stated ranges; no overflow into other state.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined:
  - In RELEASE, a repeat counter counts ticks while the same key stays low.
  - At REPEAT_TICKS, a digit key re-emits enter (x unchanged value) and the counter restarts.
  - '*' never repeats.
  - Any release tick clears the repeat counter.
- Undefined: no repeat logic, REPEAT_TICKS unused, exactly one strobe per press.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=2 unless stated):
- Reset then idle, rows all high → col_n cycles 1110,1101,1011,0111 every 4 clocks; enter=lock=0, x=0.
- Hold key '5' (row1 low when col1 driven) solid → one enter pulse with x=5, 1 cycle wide; key_held=1 until release plus 2 clean ticks; no second pulse.
- '1' then '2' then '3', each held ≥6 ticks with a full release between → three enter pulses, x=1,2,3 in order.
- '*' pressed → lock=1 for one cycle, enter=0, x keeps its previous value (3). '#' pressed → no strobe, FSM returns to SCAN after release.
- Row bounce: row low for 1 tick, high for 1 tick, repeated → no strobe. Rows 0 and 1 low together → no strobe.
- rst_n pulsed low during DEBOUNCE of '7' → outputs at reset values immediately, no strobe. With KEYPAD_REPEAT_EN and REPEAT_TICKS=3, holding '8' → enter pulses every 3 ticks, x=8.

Source files
------------

// File: rtl/keypad_entry.sv
// keypad_entry: scans a 4x4 active-low matrix keypad, debounces presses/releases and
// emits x/enter/lock strobes for the lock. Define KEYPAD_REPEAT_EN for digit auto-repeat.
module keypad_entry #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] x,
  output logic       enter,
  output logic       lock,
  output logic       key_held
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_TICKS < 1) begin : g_param_chk
    $error("keypad_entry: parameter out of range");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       sync_q, rs_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       krow_q, krow_d, kcol_q, kcol_d;
  logic [DB_W-1:0]  stab_q, stab_d, rel_q, rel_d;
  logic [3:0]       x_q, x_d;
  logic             enter_q, enter_d, lock_q, lock_d;

  logic             tick, single, same_row, is_digit, is_star, adv;
  logic [1:0]       row_idx;
  logic [3:0]       row_low, key_val;

`ifdef KEYPAD_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_TICKS + 1);
  logic [RP_W-1:0]  rep_q, rep_d;
`endif

  // Row decode and key classification from the latched (row, col).
  always_comb begin
    tick     = (div_q == DIV_W'(SCAN_DIV - 1));
    row_low  = ~rs_q;
    single   = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
    row_idx  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (row_low[r]) row_idx = 2'(r);
    end
    same_row = (rs_q == ~(4'b0001 << krow_q));
    is_star  = (krow_q == 2'd3) && (kcol_q == 2'd0);
    is_digit = (kcol_q != 2'd3) && ((krow_q != 2'd3) || (kcol_q == 2'd1));
    key_val  = (krow_q == 2'd3) ? 4'd0 : (4'(krow_q) * 4'd3 + 4'(kcol_q) + 4'd1);
  end

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    col_d   = col_q;
    krow_d  = krow_q;
    kcol_d  = kcol_q;
    stab_d  = stab_q;
    rel_d   = rel_q;
    x_d     = x_q;
    enter_d = 1'b0;
    lock_d  = 1'b0;
    adv     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (tick) begin
          if (single) begin
            krow_d  = row_idx;
            kcol_d  = col_q;
            stab_d  = '0;
            state_d = DEBOUNCE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (same_row) begin
            stab_d = stab_q + DB_W'(1);
            // Strobes are registered so they are high exactly during EMIT.
            if (stab_q == DB_W'(DEBOUNCE_CNT - 1)) begin
              state_d = EMIT;
              if (is_digit) begin
                x_d     = key_val;
                enter_d = 1'b1;
              end
              lock_d = is_star;
            end
          end else begin
            state_d = SCAN;
            adv     = 1'b1;
          end
        end
      end
      EMIT: begin
        state_d = RELEASE;
        rel_d   = '0;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = '0;
`endif
      end
      RELEASE: begin
        if (tick) begin
          if (rs_q == 4'b1111) begin
            if (rel_q == DB_W'(DEBOUNCE_CNT - 1)) begin
              rel_d   = '0;
              state_d = SCAN;
              adv     = 1'b1;
            end else begin
              rel_d = rel_q + DB_W'(1);
            end
          end else begin
            rel_d = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (same_row) begin
            if (rep_q == RP_W'(REPEAT_TICKS - 1)) begin
              rep_d   = '0;
              enter_d = is_digit;
            end else begin
              rep_d = rep_q + RP_W'(1);
            end
          end else begin
            rep_d = '0;
          end
`endif
        end
      end
      default: state_d = SCAN;
    endcase
    if (adv) col_d = col_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 4'b1111;
      rs_q    <= 4'b1111;
      state_q <= SCAN;
      div_q   <= '0;
      col_q   <= 2'd0;
      krow_q  <= 2'd0;
      kcol_q  <= 2'd0;
      stab_q  <= '0;
      rel_q   <= '0;
      x_q     <= 4'd0;
      enter_q <= 1'b0;
      lock_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      sync_q  <= row_n;
      rs_q    <= sync_q;
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      krow_q  <= krow_d;
      kcol_q  <= kcol_d;
      stab_q  <= stab_d;
      rel_q   <= rel_d;
      x_q     <= x_d;
      enter_q <= enter_d;
      lock_q  <= lock_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign col_n    = ~(4'b0001 << col_q);
  assign x        = x_q;
  assign enter    = enter_q;
  assign lock     = lock_q;
  assign key_held = (state_q == EMIT) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a keypad model drives row_n from col_n and the
// pressed-key map; expected strobes are queued at stimulus time and popped by a monitor.
module tb_keypad_entry;
  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 2;
  localparam int REPEAT_TICKS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n, col_n, x;
  logic       enter, lock, key_held;
  logic [15:0] press = '0;

  int  vec = 0, miss = 0, n_strobe = 0;
  time last_strobe_t = 0;

  typedef struct packed {logic is_lock; logic [3:0] x;} exp_t;
  exp_t sb[$];
  exp_t mon_e;

  keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT), .REPEAT_TICKS(REPEAT_TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .x(x), .enter(enter), .lock(lock), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n && (enter || lock)) begin
      n_strobe++;
      last_strobe_t = $time;
      vec++;
      if (enter && lock) begin
        miss++;
        $display("FAIL both_strobes enter=%b lock=%b required only one", enter, lock);
      end
      if (sb.size() == 0) begin
        miss++;
        $display("FAIL unexpected_strobe enter=%b lock=%b x=%0d required none", enter, lock, x);
      end else begin
        mon_e = sb.pop_front();
        if (lock !== mon_e.is_lock || enter !== !mon_e.is_lock || x !== mon_e.x) begin
          miss++;
          $display("FAIL strobe got enter=%b lock=%b x=%0d required enter=%b lock=%b x=%0d",
                   enter, lock, x, !mon_e.is_lock, mon_e.is_lock, mon_e.x);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sb(input string name, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    vec++;
    if (sb.size() != 0) begin
      miss++;
      $display("FAIL %s timeout outstanding=%0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic expect_key(input string name, input int r, input int c,
                            input logic is_lock, input logic [3:0] ex, input int hold);
    sb.push_back('{is_lock: is_lock, x: ex});
    press[r*4+c] = 1'b1;
    wait_sb(name, 80);
    cyc(hold);
    press[r*4+c] = 1'b0;
    cyc(40);
  endtask

  task automatic test_reset;
    logic [3:0] exp_col;
    cyc(3);
    vec += 5;
    if (col_n !== 4'b1110) begin miss++; $display("FAIL rst_col got %b required 1110", col_n); end
    if (x !== 4'd0)        begin miss++; $display("FAIL rst_x got %0d required 0", x); end
    if (enter !== 1'b0)    begin miss++; $display("FAIL rst_enter got %b required 0", enter); end
    if (lock !== 1'b0)     begin miss++; $display("FAIL rst_lock got %b required 0", lock); end
    if (key_held !== 1'b0) begin miss++; $display("FAIL rst_held got %b required 0", key_held); end
    rst_n = 1'b1;
    for (int p = 0; p < 16; p++) begin
      exp_col = ~(4'b0001 << ((p / 4) % 4));
      vec++;
      if (col_n !== exp_col || enter !== 1'b0 || lock !== 1'b0 || x !== 4'd0) begin
        miss++;
        $display("FAIL idle_scan p=%0d col=%b en=%b lk=%b x=%0d required col=%b en=0 lk=0 x=0",
                 p, col_n, enter, lock, x, exp_col);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_5;
    int s0 = n_strobe;
    sb.push_back('{is_lock: 1'b0, x: 4'd5});
    press[1*4+1] = 1'b1;
    wait_sb("key5", 80);
    vec++;
    if (key_held !== 1'b1) begin miss++; $display("FAIL held5 got %b required 1", key_held); end
    cyc(4);
    press[1*4+1] = 1'b0;
    cyc(1);
    vec++;
    if (key_held !== 1'b1) begin miss++; $display("FAIL held5_after_release got %b required 1", key_held); end
    cyc(30);
    vec += 2;
    if (key_held !== 1'b0) begin miss++; $display("FAIL held5_cleared got %b required 0", key_held); end
    if (n_strobe - s0 != 1) begin miss++; $display("FAIL key5_count got %0d required 1", n_strobe - s0); end
  endtask

  task automatic test_sequence_123;
    for (int k = 0; k < 3; k++) expect_key("seq123", 0, k, 1'b0, 4'(k + 1), 4);
  endtask

  task automatic test_star_hash;
    logic [3:0] c0;
    int s0;
    expect_key("star", 3, 0, 1'b1, 4'd3, 4);
    s0 = n_strobe;
    press[3*4+2] = 1'b1;
    cyc(80);
    press[3*4+2] = 1'b0;
    cyc(40);
    vec += 3;
    if (n_strobe != s0) begin miss++; $display("FAIL hash_strobe got %0d required 0", n_strobe - s0); end
    if (key_held !== 1'b0) begin miss++; $display("FAIL hash_held got %b required 0", key_held); end
    if (x !== 4'd3) begin miss++; $display("FAIL hash_x got %0d required 3", x); end
    c0 = col_n;
    cyc(4);
    vec++;
    if (col_n === c0) begin miss++; $display("FAIL hash_rescan col=%b required change from %b", col_n, c0); end
  endtask

  task automatic test_bounce_multirow;
    int s0 = n_strobe;
    for (int i = 0; i < 24; i++) begin
      press[1*4+2] = ~press[1*4+2];
      cyc(SCAN_DIV);
    end
    press = '0;
    cyc(40);
    vec++;
    if (n_strobe != s0) begin miss++; $display("FAIL bounce got %0d strobes required 0", n_strobe - s0); end
    press[0*4+0] = 1'b1;
    press[1*4+0] = 1'b1;
    cyc(100);
    press = '0;
    cyc(40);
    vec++;
    if (n_strobe != s0) begin miss++; $display("FAIL multirow got %0d strobes required 0", n_strobe - s0); end
  endtask

  task automatic test_back_to_back;
    int s0 = n_strobe;
    sb.push_back('{is_lock: 1'b0, x: 4'd5});
    press[1*4+1] = 1'b1;
    wait_sb("b2b", 80);
    press[2*4+2] = 1'b1;
    cyc(4);
    press = '0;
    cyc(60);
    vec += 2;
    if (n_strobe - s0 != 1) begin miss++; $display("FAIL b2b_count got %0d required 1", n_strobe - s0); end
    if (x !== 4'd5) begin miss++; $display("FAIL b2b_x got %0d required 5", x); end
  endtask

  task automatic test_reset_debounce;
    int s0 = n_strobe;
    int run = 0;
    int k = 0;
    press[2*4+0] = 1'b1;
    while (run < 6 && k < 120) begin
      @(negedge clk);
      run = (col_n == 4'b1110) ? run + 1 : 0;
      k++;
    end
    vec++;
    if (run < 6) begin miss++; $display("FAIL rst7_hold col held %0d cycles required 6", run); end
    rst_n = 1'b0;
    #1;
    vec++;
    if (col_n !== 4'b1110 || x !== 4'd0 || enter !== 1'b0 || lock !== 1'b0 || key_held !== 1'b0) begin
      miss++;
      $display("FAIL rst7_outputs col=%b x=%0d en=%b lk=%b held=%b required 1110/0/0/0/0",
               col_n, x, enter, lock, key_held);
    end
    press = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(60);
    vec++;
    if (n_strobe != s0) begin miss++; $display("FAIL rst7_strobe got %0d required 0", n_strobe - s0); end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat;
    int  s0 = n_strobe;
    time t0;
    sb.push_back('{is_lock: 1'b0, x: 4'd8});
    press[2*4+1] = 1'b1;
    wait_sb("rep_first", 80);
    for (int i = 0; i < 3; i++) begin
      t0 = last_strobe_t;
      sb.push_back('{is_lock: 1'b0, x: 4'd8});
      wait_sb("rep_next", 30);
      vec++;
      if (last_strobe_t - t0 != 10 * SCAN_DIV * REPEAT_TICKS) begin
        miss++;
        $display("FAIL rep_interval got %0t required %0d", last_strobe_t - t0, 10 * SCAN_DIV * REPEAT_TICKS);
      end
    end
    press = '0;
    cyc(40);
    vec++;
    if (n_strobe - s0 != 4) begin miss++; $display("FAIL rep_count got %0d required 4", n_strobe - s0); end
  endtask
`else
  task automatic test_no_repeat;
    int s0 = n_strobe;
    sb.push_back('{is_lock: 1'b0, x: 4'd8});
    press[2*4+1] = 1'b1;
    wait_sb("norep", 80);
    cyc(120);
    press = '0;
    cyc(40);
    vec++;
    if (n_strobe - s0 != 1) begin miss++; $display("FAIL norep_count got %0d required 1", n_strobe - s0); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_5();
    test_sequence_123();
    test_star_hash();
    test_bounce_multirow();
    test_back_to_back();
    test_reset_debounce();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`else
    test_no_repeat();
`endif
    vec++;
    if (sb.size() != 0) begin miss++; $display("FAIL sb_leftover got %0d required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
